dct_mac_seq: RTL and testbench
==============================

Name: dct_mac_seq

Overview:
- Initiator/reader side of the 12x12 DCT coefficient ROM.
- Buffers 12 signed 8-bit input samples, then sweeps coefficient addresses row by row.
- Multiply-accumulates each row against the buffered samples using the ROM's registered data.
- Emits 12 transform results through a valid/ready output handshake.

Parameters:
N, 12, transform length (samples per block, coefficient rows); fixed to ROM layout
DW, 8, input sample width, signed 2's complement
CW, 8, coefficient width, signed, matches ROM data
AW, 20, accumulator and dout width, signed

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
din  input  DW  signed sample
in_valid  input  1  din valid
in_ready  output  1  block accepts sample
cdct_addr  output  8  ROM address {row[3:0], col[3:0]}
cdct_data  input  CW  ROM coefficient, valid one cycle after cdct_addr
dout  output  AW  signed result for current row
out_valid  output  1  dout valid
out_ready  input  1  consumer accepts dout
out_last  output  1  high with out_valid for row 11
busy  output  1  high in COMPUTE or OUT

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after release. cdct_addr=0, dout=0, out_valid=0, out_last=0, busy=0. Sample buffer, counters and accumulator are cleared.
- States: LOAD, COMPUTE, OUT.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready writes din to sample[cnt], then cnt++.
  - The 12th accept (cnt=11) moves to COMPUTE with row k=0.
  - in_valid while in_ready=0 is ignored and not buffered.
- COMPUTE, per row k, cycles C0..C12:
  - At Cn (n=0..11), cdct_addr={k,n}.
  - At C(n+1), acc += cdct_data * sample[n], computed as a signed 8x8 to 16-bit product, sign-extended to AW.
  - acc is cleared at C0. A registered index pipe tracks n.
  - At the end of C12, dout <= final sum; out_valid=1 from C13; state moves to OUT.
  - Low nibble of cdct_addr is never above 11; row nibble is never above 11.
  - Outside COMPUTE, cdct_addr=0.
- OUT:
  - dout, out_valid and out_last are held stable while out_ready=0.
  - On the out_valid&&out_ready cycle:
    - if k<11: k++, return to COMPUTE, next C0 in the following cycle.
    - if k=11: out_valid falls, state returns to LOAD, in_ready=1 the next cycle.
- Throughput: 14 cycles per row with out_ready held high; 168 cycles per block plus 12 load cycles.
- Width: worst-case sum |(-128)*(-64)|*12 = 98304 fits in 18 bits. AW=20 cannot overflow, no saturation needed.
- Reset mid-operation: immediate return to reset values. Partial samples and results are discarded. The next block starts from sample 0, row 0.

Optional Feature:
DCT_ROUND_EN
- Defined: dout = (sum + 32) >>> 6, an arithmetic shift that removes the ROM's x64 coefficient scale. The result is sign-extended to AW; latency is unchanged.
- Undefined: dout = raw sum.

Test Plan:
- Reset released -> in_ready=1, out_valid=0, busy=0, cdct_addr=0x00, dout=0.
- Load 12 samples all =1, out_ready=1:
  - row 0 dout=462, row 1 dout=-33 (raw).
  - row 0 dout=7 with DCT_ROUND_EN.
  - out_last only on the 12th output.
- Impulse sample[0]=-128, rest 0 -> row 0 dout=-8064, row 11 dout=-5504; all rows = -128*coef[k][0].
- Address sweep check with bench ROM model -> cdct_addr runs 0x00..0x0B, 0x10..0x1B, ..., 0xB0..0xBB, with exactly one 13-cycle gap pattern per row and no address above 0xBB.
- Backpressure: hold out_ready=0 for 5 cycles at row 3 -> dout and out_valid stable, cdct_addr=0, no new row starts. Row 4 C0 occurs the cycle after the handshake.
- Assert reset during row 5 of COMPUTE, then load a fresh all-1 block -> all outputs return to reset values. Outputs then match the all-1 results (462, -33, ...).

Source files
------------

// File: rtl/dct_mac_seq.sv
// -----------------------------------------------------------------------------
// dct_mac_seq
// Reader side of a 12x12 DCT coefficient ROM. Buffers a block of 12 signed
// samples, then for each coefficient row k sweeps addresses {k, n} (n=0..11),
// multiply-accumulates the ROM's registered coefficient against sample[n],
// and presents the row result on a valid/ready output port.
//
// Optional build macro: DCT_ROUND_EN
//   defined   -> dout = (sum + 32) >>> 6  (removes the ROM's x64 scale)
//   undefined -> dout = raw sum
//
// Ports
//   clk        clock, all logic on rising edge
//   reset      asynchronous active-high reset
//   din        signed input sample        in_valid / in_ready : input handshake
//   cdct_addr  ROM address {row, col}     cdct_data : ROM data, one cycle later
//   dout       signed row result          out_valid / out_ready : output handshake
//   out_last   flags the row-11 result    busy : high while computing/emitting
// -----------------------------------------------------------------------------
module dct_mac_seq #(
  parameter int N  = 12,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] din,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           cdct_addr,
  input  logic signed [CW-1:0] cdct_data,
  output logic signed [AW-1:0] dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [3:0] LAST_IDX = 4'(N - 1);  // last sample / last row
  localparam logic [3:0] LAST_CYC = 4'(N);      // C12: final accumulate

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUT} state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt;        // samples accepted so far
  logic [3:0]            r_row;        // current coefficient row k
  logic [3:0]            r_cyc;        // compute cycle C0..C12
  logic [3:0]            r_idx;        // column whose coefficient arrives now
  logic                  r_in_ready;
  logic signed [AW-1:0]  r_acc;
  logic signed [AW-1:0]  r_dout;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_accept;
  logic                  w_handshake;
  logic signed [DW-1:0]  w_samples [N];
  logic signed [DW-1:0]  w_sample_sel;
  logic signed [15:0]    w_prod;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_result;

  assign w_accept    = in_valid && r_in_ready && (r_state == S_LOAD);
  assign w_handshake = r_out_valid && out_ready;

  // Sample buffer: one register per slot, written when its index is accepted.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_smp
      logic signed [DW-1:0] r_s;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s <= '0;
        end else if (w_accept && (r_cnt == 4'(gi))) begin
          r_s <= din;
        end
      end
      assign w_samples[gi] = r_s;
    end
  endgenerate

  // r_idx is kept below N, the guard only protects the mux from a stray index.
  assign w_sample_sel = (r_idx < LAST_CYC) ? w_samples[r_idx] : '0;
  assign w_prod       = cdct_data * w_sample_sel;
  assign w_sum        = r_acc + {{(AW-16){w_prod[15]}}, w_prod};

`ifdef DCT_ROUND_EN
  logic signed [AW-1:0] w_sum_rnd;
  assign w_sum_rnd = w_sum + AW'(32);
  assign w_result  = w_sum_rnd >>> 6;
`else
  assign w_result  = w_sum;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:    if (w_accept && (r_cnt == LAST_IDX)) w_state_next = S_COMPUTE;
      S_COMPUTE: if (r_cyc == LAST_CYC)               w_state_next = S_OUT;
      S_OUT:     if (w_handshake)
                   w_state_next = (r_row == LAST_IDX) ? S_LOAD : S_COMPUTE;
      default:   w_state_next = S_LOAD;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_row       <= '0;
      r_cyc       <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_acc       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      // Registered so that in_ready stays low while reset is held.
      r_in_ready <= (w_state_next == S_LOAD);
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_cnt <= (r_cnt == LAST_IDX) ? 4'd0 : r_cnt + 4'd1;
            r_row <= '0;
            r_cyc <= '0;
          end
        end
        S_COMPUTE: begin
          r_cyc <= r_cyc + 4'd1;
          r_idx <= (r_cyc < LAST_CYC) ? r_cyc : 4'd0;
          // Data for C0's address only arrives at C1, so C0 just clears.
          if (r_cyc == 4'd0) r_acc <= '0;
          else               r_acc <= w_sum;
          if (r_cyc == LAST_CYC) begin
            r_dout      <= w_result;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_row == LAST_IDX);
          end
        end
        S_OUT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_cyc       <= '0;
            r_row       <= (r_row == LAST_IDX) ? 4'd0 : r_row + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign cdct_addr = ((r_state == S_COMPUTE) && (r_cyc < LAST_CYC)) ? {r_row, r_cyc} : 8'h00;
  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state == S_COMPUTE) || (r_state == S_OUT);

endmodule

// File: tb/tb_dct_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_dct_mac_seq
// Drives sample blocks into dct_mac_seq against a behavioural coefficient ROM.
// Expected row results (plain sum of coef*sample) are queued when a block is
// issued; a negedge monitor pops and compares on every output handshake and
// also checks address sequencing, backpressure stability and block timing.
// -----------------------------------------------------------------------------
module tb_dct_mac_seq;

  typedef struct { int dout; bit last; } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [7:0] din = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        cdct_addr;
  logic signed [7:0] cdct_data;
  logic signed [19:0] dout;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;

  int tests = 0;
  int fails = 0;

  int coef [12][12];
  logic signed [7:0] rom [256];
  exp_t exp_q [$];

  int mon_row = 0;
  int pos = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int last_busy = 0;
  bit held_valid = 0;
  int held_dout = 0;
  bit held_last = 0;

  always #5 clk = ~clk;

  dct_mac_seq dut (
    .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .cdct_addr(cdct_addr), .cdct_data(cdct_data), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  // Behavioural ROM: registered read, one cycle latency.
  always @(posedge clk) cdct_data <= rom[cdct_addr];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input int k, input int s[12]);
    int sum = 0;
    for (int n = 0; n < 12; n++) sum += coef[k][n] * s[n];
`ifdef DCT_ROUND_EN
    sum = (sum + 32) >>> 6;
`endif
    return sum;
  endfunction

  // Monitor: addresses, backpressure stability, scoreboard pops.
  always @(negedge clk) begin
    if (reset) begin
      mon_row = 0; pos = 0; held_valid = 0; busy_cyc = 0;
    end else begin
      if (busy && !out_valid) begin
        int ea;
        ea = (pos < 12) ? ((mon_row << 4) | pos) : 0;
        check($sformatf("addr row%0d c%0d", mon_row, pos), int'(cdct_addr), ea);
        if (pos > 12) check("row_len", pos, 12);
        pos++;
      end else begin
        check("addr_idle", int'(cdct_addr), 0);
        pos = 0;
      end
      if (busy) busy_cyc++; else busy_cyc = 0;
      if (held_valid) begin
        check("bp_valid", int'(out_valid), 1);
        check("bp_dout", int'(dout), held_dout);
        check("bp_last", int'(out_last), int'(held_last));
        held_valid = 0;
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", int'(dout), 0);
            check("unexpected_out_flag", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("dout row%0d", mon_row), int'(dout), e.dout);
            check($sformatf("last row%0d", mon_row), int'(out_last), int'(e.last));
            $display("[TB] row %0d dout=%0d exp=%0d last=%0d", mon_row, int'(dout), e.dout, out_last);
          end
          if (mon_row == 11) begin
            mon_row = 0; last_busy = busy_cyc; done_cnt++;
          end else begin
            mon_row++;
          end
        end else begin
          held_valid = 1; held_dout = int'(dout); held_last = out_last;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag, input int exp_ready);
    check({tag, " in_ready"}, int'(in_ready), exp_ready);
    check({tag, " out_valid"}, int'(out_valid), 0);
    check({tag, " out_last"}, int'(out_last), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " addr"}, int'(cdct_addr), 0);
    check({tag, " dout"}, int'(dout), 0);
  endtask

  // mode: 0 = out_ready always high, 1 = random out_ready, 2 = 5-cycle stall at row 3
  task automatic run_block(input int s[12], input int mode, input bit abort);
    int i = 0, guard = 0, bp = 0, start = done_cnt;
    bit acc;
    for (int k = 0; k < 12; k++) begin
      exp_t e;
      e.dout = model(k, s); e.last = (k == 11);
      exp_q.push_back(e);
    end
    out_ready = 1'b1;
    while (i < 12 && guard < 300) begin
      in_valid = ($urandom_range(0, 3) != 0);
      din = 8'(s[i]);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    if (i < 12) check("load_timeout", i, 12);
    guard = 0;
    while (done_cnt == start && guard < 4000) begin
      in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
      din = 8'($urandom_range(0, 255));
      if (mode == 2 && out_valid && mon_row == 3 && bp < 5) begin
        out_ready = 1'b0; bp++;
      end else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
      if (abort && mon_row == 5 && busy && !out_valid) break;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (abort) begin
      check("abort_reached_row5", mon_row, 5);
      reset = 1'b1;
      #1;
      exp_q.delete();
      check_reset_vals("abort_in_reset", 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check_reset_vals("abort_release", 1);
    end else begin
      if (done_cnt == start) check("block_timeout", done_cnt, start + 1);
      check("in_ready_after_block", int'(in_ready), 1);
      if (mode == 0) check("block_busy_cycles", last_busy, 168);
      if (mode == 2) check("bp_stall_cycles", bp, 5);
    end
  endtask

  initial begin
    int r0[12] = '{63, 62, 60, 57, 53, 48, 42, 35, 27, 18, 9, -12};
    int r1[12] = '{62, 53, 35, 12, -12, -35, -53, -62, -12, 12, 27, -60};
    int s[12];
    for (int a = 0; a < 256; a++) rom[a] = '0;
    for (int k = 0; k < 12; k++)
      for (int n = 0; n < 12; n++) begin
        if (k == 0)      coef[k][n] = r0[n];
        else if (k == 1) coef[k][n] = r1[n];
        else             coef[k][n] = ((k * 37 + n * 53 + k * n * 11) % 127) - 63;
      end
    coef[11][0] = 43;
    for (int k = 0; k < 12; k++)
      for (int n = 0; n < 12; n++) rom[k * 16 + n] = 8'(coef[k][n]);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in_reset", 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("after_reset", 1);

    for (int n = 0; n < 12; n++) s[n] = 1;
    run_block(s, 0, 0);                         // all ones: 462, -33, ...

    for (int n = 0; n < 12; n++) s[n] = (n == 0) ? -128 : 0;
    run_block(s, 0, 0);                         // impulse: -128*coef[k][0]

    for (int n = 0; n < 12; n++) s[n] = int'($urandom_range(0, 255)) - 128;
    run_block(s, 2, 0);                         // backpressure at row 3

    for (int b = 0; b < 3; b++) begin
      for (int n = 0; n < 12; n++) s[n] = int'($urandom_range(0, 255)) - 128;
      run_block(s, 1, 0);
    end

    for (int n = 0; n < 12; n++) s[n] = (n % 2 == 0) ? -128 : 127;
    run_block(s, 0, 0);                         // extreme magnitudes

    for (int n = 0; n < 12; n++) s[n] = int'($urandom_range(0, 255)) - 128;
    run_block(s, 0, 1);                         // reset during row 5

    for (int n = 0; n < 12; n++) s[n] = 1;
    run_block(s, 0, 0);                         // fresh block after abort

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
